neo_sample_writer: RTL and testbench
====================================

NEO_SAMPLE_WRITER -- requirements
Module: neo_sample_writer

Interface
REQ-001 Parameter N, default 8: signed sample width written to memory, in bits.
REQ-002 Parameter M, default 16: memory locations per frame.
REQ-003 Parameter IW, default 12: signed input sample width, in bits; IW >= N.
REQ-004 Port Clk  input  1  system clock; all logic SHALL be clocked on the rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port in_data  input  IW  signed incoming sample.
REQ-007 Port in_valid  input  1  in_data valid.
REQ-008 Port in_ready  output  1  block can accept a sample.
REQ-009 Port we  output  1  memory write enable.
REQ-010 Port waddr  output  $clog2(M)+1  memory write address; MSB always 0.
REQ-011 Port wdata  output  N  signed sample written to memory.
REQ-012 Port frame_valid  output  1  M samples are resident in memory for the NEO calculator.
REQ-013 Port frame_ack  input  1  calculator has consumed the frame.
REQ-014 Port frame_cnt  output  8  completed-frame counter, wraps 255 -> 0.
REQ-015 Port sat_seen  output  1  a sample in the current frame was clamped.

Function
REQ-016 FSM states: FILL, LAST, HANDOFF.
REQ-017 Sample acceptance: in_valid and in_ready both high on a rising edge.
REQ-018 FILL: in_ready = 1; frame_valid = 0.
REQ-019 Write timing: each accepted sample SHALL be written one cycle later with we = 1, waddr = wr_ptr, and wdata = the narrowed sample.
REQ-020 Pointer: wr_ptr starts at 0 and increments by 1 per accepted sample.
REQ-021 FILL -> LAST: on acceptance of the sample at wr_ptr = M-1.
REQ-022 LAST: lasts exactly 1 cycle; in_ready = 0; we = 1 for address M-1; then -> HANDOFF.
REQ-023 HANDOFF: frame_valid = 1; in_ready = 0; we = 0.
REQ-024 HANDOFF exit: frame_ack = 1 -> FILL next cycle; wr_ptr <- 0; frame_cnt increments by 1; sat_seen clears.
REQ-025 frame_ack SHALL be ignored in FILL and LAST.
REQ-026 frame_valid SHALL never be high while we is high; the final write always completes first.
REQ-027 Latency: last accepted sample to frame_valid rising = 2 cycles.
REQ-028 in_valid with in_ready low: no write occurs and the sample is not consumed; the source holds it.
REQ-029 Back-to-back in_valid in FILL SHALL sustain one sample per cycle.
REQ-030 Narrowing without the macro: wdata = low N bits of in_data (two's-complement wrap).

Reset
REQ-031 On reset: state = FILL, wr_ptr = 0, we = 0, waddr = 0, wdata = 0, frame_valid = 0, frame_cnt = 0, sat_seen = 0; in_ready = 1 from the first cycle after reset.
REQ-032 Reset mid-frame or in HANDOFF: the partial frame is discarded, no pending write is issued, and frame_cnt returns to 0.

Configuration
REQ-033 Macro NEO_SAMPLE_SAT_EN defined: in_data SHALL be clamped to [-2^(N-1), 2^(N-1)-1]; any clamp sets sat_seen, which holds until the frame is acked or reset occurs.
REQ-034 Macro NEO_SAMPLE_SAT_EN undefined: truncation per REQ-030; sat_seen is tied to 0.

Verification
REQ-035 Reset, then 16 samples 1..16 on consecutive cycles -> we on 16 consecutive cycles, waddr 0..15, wdata 1..16; frame_valid high 2 cycles after the last accept; in_ready 0 from the LAST cycle.
REQ-036 In HANDOFF, hold frame_ack = 0 for 10 cycles with in_valid = 1 -> no writes, frame_valid stays 1; pulse frame_ack -> FILL, frame_cnt = 1, next accepted sample written to waddr 0.
REQ-037 in_data = 300 and -300 (IW = 12, N = 8): with NEO_SAMPLE_SAT_EN -> wdata 127 and -128, sat_seen = 1; without it -> wdata 44 and -44, sat_seen = 0.
REQ-038 Assert reset after 9 accepted samples -> all outputs at reset values the next cycle; the next frame writes from waddr 0.
REQ-039 Pulse frame_ack in FILL, gap in_valid randomly -> no state change from the ack; waddr sequence remains contiguous 0..15.
REQ-040 Run 256 frames -> frame_cnt wraps from 255 to 0.

Source files
------------

// File: rtl/neo_sample_writer.sv
// Buffers one frame of M narrowed samples into memory and hands it to the NEO calculator.
// Optional clamping instead of wrap-around is enabled by defining NEO_SAMPLE_SAT_EN.
module neo_sample_writer #(
  parameter int unsigned N  = 8,
  parameter int unsigned M  = 16,
  parameter int unsigned IW = 12
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic signed [IW-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    we,
  output logic [$clog2(M):0]      waddr,
  output logic signed [N-1:0]     wdata,
  output logic                    frame_valid,
  input  logic                    frame_ack,
  output logic [7:0]              frame_cnt,
  output logic                    sat_seen
);

  localparam int unsigned AW = $clog2(M) + 1;
  localparam logic [AW-1:0] LastAddr = AW'(M - 1);

  typedef enum logic [1:0] {StFill, StLast, StHandoff} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q;
  logic                 accept, last_accept, ack_take;
  logic signed [N-1:0]  narrow;
  logic                 clamp;

  assign accept      = in_valid && (state_q == StFill);
  assign last_accept = accept && (wr_ptr_q == LastAddr);
  assign ack_take    = frame_ack && (state_q == StHandoff);
  assign in_ready    = (state_q == StFill);
  assign frame_valid = (state_q == StHandoff);

`ifdef NEO_SAMPLE_SAT_EN
  localparam logic signed [IW-1:0] MaxV = {{(IW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [IW-1:0] MinV = {{(IW-N+1){1'b1}}, {(N-1){1'b0}}};

  always_comb begin
    clamp  = 1'b0;
    narrow = in_data[N-1:0];
    if (in_data > MaxV) begin
      clamp  = 1'b1;
      narrow = MaxV[N-1:0];
    end else if (in_data < MinV) begin
      clamp  = 1'b1;
      narrow = MinV[N-1:0];
    end
  end
`else
  // Upper input bits are intentionally dropped (two's-complement wrap).
  logic unused_in;
  assign unused_in = ^in_data;
  assign narrow    = in_data[N-1:0];
  assign clamp     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:    if (last_accept) state_d = StLast;
      StLast:    state_d = StHandoff;
      StHandoff: if (frame_ack) state_d = StFill;
      default:   state_d = StFill;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= StFill;
      wr_ptr_q  <= '0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      frame_cnt <= '0;
      sat_seen  <= 1'b0;
    end else begin
      state_q <= state_d;
      we      <= accept;
      if (accept) begin
        waddr    <= wr_ptr_q;
        wdata    <= narrow;
        wr_ptr_q <= last_accept ? '0 : wr_ptr_q + AW'(1);
        if (clamp) sat_seen <= 1'b1;
      end
      if (ack_take) begin
        wr_ptr_q  <= '0;
        frame_cnt <= frame_cnt + 8'd1;
        sat_seen  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neo_sample_writer.sv
// Directed bench for neo_sample_writer: table-driven first frame plus handoff, saturation,
// ack-in-fill, mid-frame reset and frame counter wrap sequences.
module tb_neo_sample_writer;

  logic              Clk = 1'b0;
  logic              reset;
  logic signed [11:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              we;
  logic [4:0]        waddr;
  logic signed [7:0] wdata;
  logic              frame_valid;
  logic              frame_ack;
  logic [7:0]        frame_cnt;
  logic              sat_seen;

  int n_checks = 0;
  int n_err    = 0;

`ifdef NEO_SAMPLE_SAT_EN
  localparam int ExpHi = 127, ExpLo = -128, ExpSat = 1;
`else
  localparam int ExpHi = 44, ExpLo = -44, ExpSat = 0;
`endif

  neo_sample_writer #(.N(8), .M(16), .IW(12)) dut (
    .Clk         (Clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .frame_cnt   (frame_cnt),
    .sat_seen    (sat_seen)
  );

  initial forever #5 Clk = ~Clk;

  typedef struct {
    bit vld;
    int data;
    bit ack;
    bit e_we;
    int e_addr;
    int e_wdata;
    bit e_rdy;
    bit e_fv;
  } vec_t;

  vec_t tbl[17];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_frame(output int first_addr);
    int b;
    first_addr = -1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 12'(i);
      step();
      if (i == 0) first_addr = int'(waddr);
    end
    in_valid = 1'b0;
    b = 0;
    while (!frame_valid && b < 5) begin
      step();
      b++;
    end
    chk("frame_valid_wait", int'(frame_valid), 1);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
  endtask

  initial begin
    int ptr, fa, iter;
    bit v, a;

    for (int k = 0; k < 16; k++)
      tbl[k] = '{1'b1, k + 1, (k == 4), 1'b1, k, k + 1, (k != 15), 1'b0};
    // Ack during LAST must be ignored; next edge still lands in HANDOFF.
    tbl[16] = '{1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; frame_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_we", int'(we), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_wdata", int'(wdata), 0);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_cnt", int'(frame_cnt), 0);
    chk("rst_sat", int'(sat_seen), 0);
    chk("rst_ready", int'(in_ready), 1);

    // First frame: samples 1..16 back to back.
    for (int i = 0; i < 17; i++) begin
      in_valid  = tbl[i].vld;
      in_data   = 12'(tbl[i].data);
      frame_ack = tbl[i].ack;
      step();
      chk($sformatf("tbl%0d_we", i), int'(we), int'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("tbl%0d_waddr", i), int'(waddr), tbl[i].e_addr);
        chk($sformatf("tbl%0d_wdata", i), int'(wdata), tbl[i].e_wdata);
      end
      chk($sformatf("tbl%0d_ready", i), int'(in_ready), int'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_fv", i), int'(frame_valid), int'(tbl[i].e_fv));
      chk($sformatf("tbl%0d_cnt", i), int'(frame_cnt), 0);
    end

    // HANDOFF hold with a pushy source.
    frame_ack = 1'b0; in_valid = 1'b1; in_data = 12'(99);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_we", int'(we), 0);
      chk("hold_fv", int'(frame_valid), 1);
      chk("hold_ready", int'(in_ready), 0);
    end
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk("ack_fv", int'(frame_valid), 0);
    chk("ack_cnt", int'(frame_cnt), 1);
    chk("ack_ready", int'(in_ready), 1);
    chk("ack_we", int'(we), 0);
    in_data = 12'(5);
    step();
    chk("post_ack_we", int'(we), 1);
    chk("post_ack_waddr", int'(waddr), 0);
    chk("post_ack_wdata", int'(wdata), 5);

    // Out-of-range samples.
    in_data = 12'(300);
    step();
    chk("pos300_wdata", int'(wdata), ExpHi);
    chk("pos300_waddr", int'(waddr), 1);
    chk("pos300_sat", int'(sat_seen), ExpSat);
    in_data = 12'(-300);
    step();
    chk("neg300_wdata", int'(wdata), ExpLo);
    chk("neg300_waddr", int'(waddr), 2);
    chk("neg300_sat", int'(sat_seen), ExpSat);

    // Gappy source plus stray acks while filling.
    ptr = 3;
    iter = 0;
    while (ptr < 16 && iter < 300) begin
      v = 1'($urandom_range(0, 1));
      a = 1'($urandom_range(0, 1));
      in_valid  = v;
      in_data   = 12'(ptr);
      frame_ack = a;
      step();
      chk("gap_we", int'(we), int'(v));
      if (v) begin
        chk("gap_waddr", int'(waddr), ptr);
        ptr++;
      end
      chk("gap_cnt", int'(frame_cnt), 1);
      chk("gap_ready", int'(in_ready), int'(ptr < 16));
      iter++;
    end
    chk("gap_done", ptr, 16);
    in_valid = 1'b0; frame_ack = 1'b0;
    step();
    chk("gap_fv", int'(frame_valid), 1);
    chk("gap_sat_held", int'(sat_seen), ExpSat);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk("gap_ack_cnt", int'(frame_cnt), 2);
    chk("gap_ack_sat", int'(sat_seen), 0);

    // Reset after 9 accepted samples.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 12'(i + 40);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("mid_rst_we", int'(we), 0);
    chk("mid_rst_waddr", int'(waddr), 0);
    chk("mid_rst_wdata", int'(wdata), 0);
    chk("mid_rst_cnt", int'(frame_cnt), 0);
    chk("mid_rst_fv", int'(frame_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    run_frame(fa);
    chk("mid_rst_first_addr", fa, 0);
    chk("mid_rst_cnt_after", int'(frame_cnt), 1);

    // Frame counter wrap.
    for (int f = 0; f < 254; f++) run_frame(fa);
    chk("cnt_255", int'(frame_cnt), 255);
    run_frame(fa);
    chk("cnt_wrap", int'(frame_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
